// File: rtl/cluster_request_scheduler_if.sv
// Signal bundle between the requesters, the request scheduler and the memory cluster.
// SCHED_STATS_EN adds the per-port freeze stall counter bus.
interface cluster_request_scheduler_if;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [35:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_wen;
    logic [2:0]  port_valid;
    logic [35:0] port_addr;
    logic [47:0] port_data;
    logic [2:0]  port_wen;
    logic [5:0]  port_tag;
    logic        freeze_inputs;
    logic [2:0]  cl_valid_out;
    logic [5:0]  cl_tag_out;
    logic [47:0] cl_data_out;
    logic [2:0]  rsp_valid;
    logic [5:0]  rsp_tag;
    logic [47:0] rsp_data;
    logic        busy;
    logic [2:0]  err_underflow;
`ifdef SCHED_STATS_EN
    logic [47:0] stall_cnt;

    modport master (
        output req_valid, req_addr, req_data, req_wen, freeze_inputs,
               cl_valid_out, cl_tag_out, cl_data_out,
        input  req_ready, port_valid, port_addr, port_data, port_wen, port_tag,
               rsp_valid, rsp_tag, rsp_data, busy, err_underflow, stall_cnt
    );
    modport slave (
        input  req_valid, req_addr, req_data, req_wen, freeze_inputs,
               cl_valid_out, cl_tag_out, cl_data_out,
        output req_ready, port_valid, port_addr, port_data, port_wen, port_tag,
               rsp_valid, rsp_tag, rsp_data, busy, err_underflow, stall_cnt
    );
`else
    modport master (
        output req_valid, req_addr, req_data, req_wen, freeze_inputs,
               cl_valid_out, cl_tag_out, cl_data_out,
        input  req_ready, port_valid, port_addr, port_data, port_wen, port_tag,
               rsp_valid, rsp_tag, rsp_data, busy, err_underflow
    );
    modport slave (
        input  req_valid, req_addr, req_data, req_wen, freeze_inputs,
               cl_valid_out, cl_tag_out, cl_data_out,
        output req_ready, port_valid, port_addr, port_data, port_wen, port_tag,
               rsp_valid, rsp_tag, rsp_data, busy, err_underflow
    );
`endif
endinterface

// File: rtl/cluster_request_scheduler.sv
// Three-port request scheduler: per-port FIFOs, rolling 2-bit tags, freeze-stable issue registers.
// Define SCHED_STATS_EN to add saturating per-port freeze stall counters (stall_cnt).
module cluster_request_scheduler #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4
) (
    input logic clk,
    input logic reset,
    cluster_request_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 29;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    OUT_LIM  = 4'(MAX_OUT);

    logic [EW-1:0] r_mem   [3][DEPTH];
    logic [AW-1:0] r_wptr  [3];
    logic [AW-1:0] r_rptr  [3];
    logic [CW-1:0] r_cnt   [3];
    logic [2:0]    r_pv;
    logic [11:0]   r_paddr [3];
    logic [15:0]   r_pdata [3];
    logic [2:0]    r_pwen;
    logic [1:0]    r_ptag  [3];
    logic [1:0]    r_tag   [3];
    logic [2:0]    r_out   [3];
    logic [2:0]    r_err;

    logic [2:0]    w_full, w_push, w_acc, w_load, w_rsp;
    logic [EW-1:0] w_head  [3];
    logic [3:0]    w_osum  [3];
    logic [35:0]   w_paddr_v;
    logic [47:0]   w_pdata_v;
    logic [5:0]    w_ptag_v;
    logic          w_busy;

    // Load only when the slot frees this edge and the tag space has room after this edge's accept.
    always_comb begin
        w_full = '0;
        w_push = '0;
        w_acc  = '0;
        w_load = '0;
        w_rsp  = '0;
        for (int i = 0; i < 3; i++) begin
            w_full[i] = (r_cnt[i] == FULL_CNT);
            w_push[i] = bus.req_valid[i] & ~w_full[i];
            w_acc[i]  = r_pv[i] & ~bus.freeze_inputs;
            w_rsp[i]  = bus.cl_valid_out[i];
            w_osum[i] = {1'b0, r_out[i]} + {3'b000, w_acc[i]};
            w_load[i] = (~r_pv[i] | w_acc[i]) & (r_cnt[i] != '0) & (w_osum[i] < OUT_LIM);
            w_head[i] = r_mem[i][r_rptr[i]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_push[i])
                r_mem[i][r_wptr[i]] <= {bus.req_wen[i], bus.req_data[16*i +: 16], bus.req_addr[12*i +: 12]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pv   <= '0;
            r_pwen <= '0;
            r_err  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
                r_cnt[i]   <= '0;
                r_paddr[i] <= '0;
                r_pdata[i] <= '0;
                r_ptag[i]  <= '0;
                r_tag[i]   <= '0;
                r_out[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_push[i])
                    r_wptr[i] <= r_wptr[i] + AW'(1);
                if (w_load[i])
                    r_rptr[i] <= r_rptr[i] + AW'(1);
                if (w_push[i] & ~w_load[i])
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                else if (~w_push[i] & w_load[i])
                    r_cnt[i] <= r_cnt[i] - CW'(1);

                if (w_rsp[i] && (r_out[i] == 3'd0))
                    r_err[i] <= 1'b1;
                if (w_acc[i] & ~w_rsp[i])
                    r_out[i] <= r_out[i] + 3'd1;
                else if (w_rsp[i] & ~w_acc[i] & (r_out[i] != 3'd0))
                    r_out[i] <= r_out[i] - 3'd1;

                if (w_load[i]) begin
                    r_pv[i]    <= 1'b1;
                    r_paddr[i] <= w_head[i][11:0];
                    r_pdata[i] <= w_head[i][27:12];
                    r_pwen[i]  <= w_head[i][28];
                    r_ptag[i]  <= r_tag[i];
                    r_tag[i]   <= r_tag[i] + 2'd1;
                end else if (w_acc[i]) begin
                    r_pv[i]    <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_paddr_v = '0;
        w_pdata_v = '0;
        w_ptag_v  = '0;
        w_busy    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_paddr_v[12*i +: 12] = r_paddr[i];
            w_pdata_v[16*i +: 16] = r_pdata[i];
            w_ptag_v[2*i +: 2]    = r_ptag[i];
            if ((r_cnt[i] != '0) || r_pv[i] || (r_out[i] != 3'd0))
                w_busy = 1'b1;
        end
    end

    assign bus.req_ready     = ~w_full;
    assign bus.port_valid    = r_pv;
    assign bus.port_addr     = w_paddr_v;
    assign bus.port_data     = w_pdata_v;
    assign bus.port_wen      = r_pwen;
    assign bus.port_tag      = w_ptag_v;
    assign bus.rsp_valid     = bus.cl_valid_out;
    assign bus.rsp_tag       = bus.cl_tag_out;
    assign bus.rsp_data      = bus.cl_data_out;
    assign bus.busy          = w_busy;
    assign bus.err_underflow = r_err;

`ifdef SCHED_STATS_EN
    logic [15:0] r_stall [3];
    logic [47:0] w_stall_v;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset)
                r_stall[i] <= '0;
            else if (r_pv[i] & bus.freeze_inputs & (r_stall[i] != 16'hFFFF))
                r_stall[i] <= r_stall[i] + 16'd1;
        end
    end

    always_comb begin
        w_stall_v = '0;
        for (int i = 0; i < 3; i++)
            w_stall_v[16*i +: 16] = r_stall[i];
    end

    assign bus.stall_cnt = w_stall_v;
`endif
endmodule

// File: tb/tb_cluster_request_scheduler.sv
// Bench for cluster_request_scheduler: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_cluster_request_scheduler;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    cluster_request_scheduler_if bus();

    cluster_request_scheduler #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: per-port request queue, one issue slot, in-flight tag queue.
    logic [28:0] m_fifo [3][$];
    int          m_infl [3][$];
    bit          m_iv   [3];
    logic [11:0] m_ia   [3];
    logic [15:0] m_id   [3];
    bit          m_iw   [3];
    int          m_it   [3];
    int          m_tag  [3];
    bit          m_err  [3];
    int          m_stall[3];
    bit          m_live = 1'b0;

    logic [1:0]  acc_tag2  [$];
    logic [11:0] acc_addr0 [$];
    int          pushed;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_fifo[i].delete();
                m_infl[i].delete();
                m_iv[i] = 0; m_tag[i] = 0; m_err[i] = 0; m_stall[i] = 0;
            end
            m_live = 1'b1;
        end else if (m_live) begin
            for (int i = 0; i < 3; i++) begin
                bit rdy, push, acc, rsp, load;
                logic [28:0] e;
                rdy  = m_fifo[i].size() < DEPTH;
                push = bus.req_valid[i] && rdy;
                acc  = m_iv[i] && !bus.freeze_inputs;
                rsp  = bus.cl_valid_out[i];
                load = (!m_iv[i] || acc) && (m_fifo[i].size() > 0) &&
                       ((m_infl[i].size() + int'(acc)) < MAX_OUT);
                if (m_iv[i] && bus.freeze_inputs && m_stall[i] < 65535) m_stall[i]++;
                if (rsp && m_infl[i].size() == 0) begin
                    m_err[i] = 1;
                end else begin
                    if (acc) m_infl[i].push_back(m_it[i]);
                    if (rsp) void'(m_infl[i].pop_front());
                end
                if (load) begin
                    e = m_fifo[i].pop_front();
                    m_iv[i] = 1; m_ia[i] = e[11:0]; m_id[i] = e[27:12]; m_iw[i] = e[28];
                    m_it[i] = m_tag[i];
                    m_tag[i] = (m_tag[i] + 1) % 4;
                end else if (acc) begin
                    m_iv[i] = 0;
                end
                if (push)
                    m_fifo[i].push_back({bus.req_wen[i], bus.req_data[16*i +: 16], bus.req_addr[12*i +: 12]});
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && bus.port_valid[2] && !bus.freeze_inputs) acc_tag2.push_back(bus.port_tag[5:4]);
        if (!reset && bus.port_valid[0] && !bus.freeze_inputs) acc_addr0.push_back(bus.port_addr[11:0]);
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (m_live) begin
            logic [2:0] e_rdy, e_pv, e_err;
            bit e_busy;
            e_busy = 0;
            for (int i = 0; i < 3; i++) begin
                e_rdy[i] = m_fifo[i].size() < DEPTH;
                e_pv[i]  = m_iv[i];
                e_err[i] = m_err[i];
                if (m_fifo[i].size() > 0 || m_iv[i] || m_infl[i].size() > 0) e_busy = 1;
            end
            chk("req_ready", 64'(bus.req_ready), 64'(e_rdy));
            chk("port_valid", 64'(bus.port_valid), 64'(e_pv));
            chk("busy", 64'(bus.busy), 64'(e_busy));
            chk("err_underflow", 64'(bus.err_underflow), 64'(e_err));
            for (int i = 0; i < 3; i++) begin
                if (m_iv[i]) begin
                    chk("port_addr", 64'(bus.port_addr[12*i +: 12]), 64'(m_ia[i]));
                    chk("port_data", 64'(bus.port_data[16*i +: 16]), 64'(m_id[i]));
                    chk("port_wen", 64'(bus.port_wen[i]), 64'(m_iw[i]));
                    chk("port_tag", 64'(bus.port_tag[2*i +: 2]), 64'(m_it[i]));
                end
`ifdef SCHED_STATS_EN
                chk("stall_cnt", 64'(bus.stall_cnt[16*i +: 16]), 64'(m_stall[i]));
`endif
            end
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(bus.cl_valid_out));
            chk("rsp_tag", 64'(bus.rsp_tag), 64'(bus.cl_tag_out));
            chk("rsp_data", 64'(bus.rsp_data), 64'(bus.cl_data_out));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.req_wen = '0;
        bus.freeze_inputs = 1'b0;
        bus.cl_valid_out = '0; bus.cl_tag_out = '0; bus.cl_data_out = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Cluster stand-in: answers the oldest in-flight request of a port with probability pct.
    task automatic set_rsp(int pct);
        logic [2:0] v;
        logic [5:0] t;
        v = '0;
        t = '0;
        for (int i = 0; i < 3; i++) begin
            if (m_infl[i].size() > 0 && $urandom_range(99) < pct) begin
                v[i] = 1'b1;
                t[2*i +: 2] = 2'(m_infl[i][0]);
            end
        end
        bus.cl_valid_out = v;
        bus.cl_tag_out   = t;
        bus.cl_data_out  = {16'($urandom), 32'($urandom)};
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_ready", 64'(bus.req_ready), 64'h7);
        chk("rst_pvalid", 64'(bus.port_valid), 64'h0);
        chk("rst_ptag", 64'(bus.port_tag), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        reset = 1'b0;

        // Single read on port 1
        bus.req_valid = 3'b001; bus.req_addr = 36'h005;
        tick();
        bus.req_valid = '0;
        chk("p1_not_yet", 64'(bus.port_valid[0]), 64'h0);
        tick();
        chk("p1_pvalid", 64'(bus.port_valid[0]), 64'h1);
        chk("p1_tag", 64'(bus.port_tag[1:0]), 64'h0);
        chk("p1_addr", 64'(bus.port_addr[11:0]), 64'h005);
        tick();
        bus.cl_valid_out = 3'b001; bus.cl_tag_out = '0; bus.cl_data_out = 48'hBEEF;
        #1;
        chk("p1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("p1_rsp_data", 64'(bus.rsp_data[15:0]), 64'hBEEF);
        tick();
        bus.cl_valid_out = '0;
        chk("p1_busy_clear", 64'(bus.busy), 64'h0);

        // Freeze hold on port 2
        bus.freeze_inputs = 1'b1;
        bus.req_valid = 3'b010; bus.req_addr = 36'h3FF << 12;
        bus.req_data = 48'h1234 << 16; bus.req_wen = 3'b010;
        tick();
        bus.req_valid = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("p2_hold_valid", 64'(bus.port_valid[1]), 64'h1);
            chk("p2_hold_addr", 64'(bus.port_addr[23:12]), 64'h3FF);
            chk("p2_hold_data", 64'(bus.port_data[31:16]), 64'h1234);
            chk("p2_hold_wen", 64'(bus.port_wen[1]), 64'h1);
            chk("p2_hold_tag", 64'(bus.port_tag[3:2]), 64'h0);
            tick();
        end
        bus.freeze_inputs = 1'b0;
        tick();
        chk("p2_accepted", 64'(bus.port_valid[1]), 64'h0);
        chk("p2_outstanding", 64'(bus.busy), 64'h1);
        bus.cl_valid_out = 3'b010; bus.cl_tag_out = '0;
        tick();
        bus.cl_valid_out = '0;

        // Six reads on port 3, no responses: tag space stops issue at four
        acc_tag2.delete();
        pushed = 0;
        for (int c = 0; c < 30; c++) begin
            bit go;
            go = (pushed < 6) && bus.req_ready[2];
            bus.req_valid = go ? 3'b100 : 3'b000;
            bus.req_addr  = {12'(pushed), 24'h0};
            tick();
            if (go) pushed++;
        end
        bus.req_valid = '0;
        chk("p3_n_accepted", 64'(acc_tag2.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            if (acc_tag2.size() > k) chk("p3_tag_seq", 64'(acc_tag2[k]), 64'(k));
        chk("p3_stalled", 64'(bus.port_valid[2]), 64'h0);
        bus.cl_valid_out = 3'b100; bus.cl_tag_out = 6'h00;
        tick();
        bus.cl_valid_out = '0;
        tick();
        chk("p3_reissue_valid", 64'(bus.port_valid[2]), 64'h1);
        chk("p3_reissue_tag", 64'(bus.port_tag[5:4]), 64'h0);
        chk("p3_reissue_addr", 64'(bus.port_addr[35:24]), 64'h4);

        // Continuous freeze, five pushes on port 1
        do_reset();
        bus.freeze_inputs = 1'b1;
        pushed = 0;
        for (int c = 0; c < 12; c++) begin
            bit go;
            go = (pushed < 5) && bus.req_ready[0];
            bus.req_valid = go ? 3'b001 : 3'b000;
            bus.req_addr  = {24'h0, 12'h100 + 12'(pushed)};
            tick();
            if (go) pushed++;
        end
        bus.req_valid = '0;
        chk("p4_pushed", 64'(pushed), 64'd5);
        chk("p4_ready_low", 64'(bus.req_ready[0]), 64'h0);
        acc_addr0.delete();
        bus.freeze_inputs = 1'b0;
        for (int c = 0; c < 30; c++) begin
            set_rsp(100);
            tick();
        end
        bus.cl_valid_out = '0;
        chk("p4_n_issued", 64'(acc_addr0.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            if (acc_addr0.size() > k) chk("p4_order", 64'(acc_addr0[k]), 64'(12'h100 + 12'(k)));

        // Response with nothing outstanding
        do_reset();
        bus.cl_valid_out = 3'b001;
        tick();
        bus.cl_valid_out = '0;
        chk("p5_err_set", 64'(bus.err_underflow), 64'h1);
        chk("p5_busy", 64'(bus.busy), 64'h0);
        tick(); tick(); tick();
        chk("p5_err_sticky", 64'(bus.err_underflow), 64'h1);

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            bus.req_valid     = 3'($urandom);
            bus.req_addr      = {4'($urandom), 32'($urandom)};
            bus.req_data      = {16'($urandom), 32'($urandom)};
            bus.req_wen       = 3'($urandom);
            bus.freeze_inputs = ($urandom_range(3) == 0);
            set_rsp(40);
            tick();
        end

        // Reset while all ports are busy
        bus.req_valid = 3'b111; bus.freeze_inputs = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        bus.cl_valid_out = '0;
        #1;
        chk("p6_pvalid", 64'(bus.port_valid), 64'h0);
        chk("p6_paddr", 64'(bus.port_addr), 64'h0);
        chk("p6_pdata", 64'(bus.port_data), 64'h0);
        chk("p6_pwen", 64'(bus.port_wen), 64'h0);
        chk("p6_ptag", 64'(bus.port_tag), 64'h0);
        chk("p6_busy", 64'(bus.busy), 64'h0);
        chk("p6_err", 64'(bus.err_underflow), 64'h0);
        chk("p6_ready", 64'(bus.req_ready), 64'h7);
        clear_inputs();
        reset = 1'b0;
        bus.req_valid = 3'b001; bus.req_addr = 36'h0AB;
        tick();
        bus.req_valid = '0;
        tick();
        chk("p6_restart_valid", 64'(bus.port_valid[0]), 64'h1);
        chk("p6_restart_tag", 64'(bus.port_tag[1:0]), 64'h0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
